// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator (640x480@60 by default) running entirely in
//   the clk_in domain. A clock divider produces a one-cycle pixel enable.
//   Horizontal and vertical counters advance on that enable. Sync, active
//   video and pixel coordinates are registered decodes of the counters.
//
// Ports
//   clk_in       in   board clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable; low returns to the frame origin and holds
//   pix_en       out  one-clk_in-cycle pulse per pixel period
//   hsync        out  horizontal sync, SYNC_POL when asserted
//   vsync        out  vertical sync, SYNC_POL when asserted
//   video_on     out  high inside the visible window
//   x, y         out  pixel column/row while video_on, else 0
//   line_start   out  pulse with pix_en when the line restarts at h_cnt 0
//   frame_start  out  pulse with pix_en when the frame restarts at (0,0)
//
// Timing notes
//   pix_en, line_start and frame_start are registered alongside the counter
//   update. In the cycle where pix_en is high, h_cnt/v_cnt already hold the
//   pixel that this pulse starts. The decoded outputs follow one cycle later.
//
//   After reset, or after en has been low, the counters sit at the origin
//   in an "armed" state. The first pixel enable presents pixel (0,0)
//   without advancing the counters, and it carries line_start and
//   frame_start. Every later pulse advances the raster by one pixel. This
//   means a restarted raster always begins with a frame_start at the origin.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] CNT_ONE    = 10'd1;

    // Raster phases. These are decoded from the counters, not stored, so
    // the phase can never disagree with the count.
    typedef enum logic [1:0] {
        H_ST_ACTIVE,
        H_ST_FP,
        H_ST_SYNC,
        H_ST_BP
    } h_state_t;

    typedef enum logic [1:0] {
        V_ST_ACTIVE,
        V_ST_FP,
        V_ST_SYNC,
        V_ST_BP
    } v_state_t;

    // State registers
    logic [DIV_W-1:0] div_reg, div_next;
    logic             armed_reg, armed_next;
    logic [9:0]       h_cnt_reg, h_cnt_next;
    logic [9:0]       v_cnt_reg, v_cnt_next;
    logic             pix_en_reg, pix_en_next;
    logic             line_start_reg, line_start_next;
    logic             frame_start_reg, frame_start_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             video_on_reg, video_on_next;
    logic [9:0]       x_reg, x_next;
    logic [9:0]       y_reg, y_next;

    h_state_t h_state;
    v_state_t v_state;
    logic     tick;
    logic     decode_ok;

    // tick is high in the clk_in cycle that ends a pixel period.
    assign tick = en && (div_reg == DIV_LAST);

    // Phase decode of the current counters
    always_comb begin
        h_state = H_ST_BP;
        if (h_cnt_reg < H_ACT_END) begin
            h_state = H_ST_ACTIVE;
        end else if (h_cnt_reg < H_SYNC_BEG) begin
            h_state = H_ST_FP;
        end else if (h_cnt_reg < H_SYNC_END) begin
            h_state = H_ST_SYNC;
        end

        v_state = V_ST_BP;
        if (v_cnt_reg < V_ACT_END) begin
            v_state = V_ST_ACTIVE;
        end else if (v_cnt_reg < V_SYNC_BEG) begin
            v_state = V_ST_FP;
        end else if (v_cnt_reg < V_SYNC_END) begin
            v_state = V_ST_SYNC;
        end
    end

    // Divider, counters and start pulses
    always_comb begin
        div_next         = div_reg;
        armed_next       = armed_reg;
        h_cnt_next       = h_cnt_reg;
        v_cnt_next       = v_cnt_reg;
        pix_en_next      = 1'b0;
        line_start_next  = 1'b0;
        frame_start_next = 1'b0;

        if (!en) begin
            div_next   = '0;
            h_cnt_next = '0;
            v_cnt_next = '0;
            armed_next = 1'b1;
        end else begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_ONE;
            if (tick) begin
                pix_en_next = 1'b1;
                if (armed_reg) begin
                    // The first pixel after a restart is the origin itself.
                    armed_next       = 1'b0;
                    line_start_next  = 1'b1;
                    frame_start_next = 1'b1;
                end else if (h_cnt_reg == H_LAST) begin
                    h_cnt_next      = '0;
                    line_start_next = 1'b1;
                    if (v_cnt_reg == V_LAST) begin
                        v_cnt_next       = '0;
                        frame_start_next = 1'b1;
                    end else begin
                        v_cnt_next = v_cnt_reg + CNT_ONE;
                    end
                end else begin
                    h_cnt_next = h_cnt_reg + CNT_ONE;
                end
            end
        end
    end

    // Registered output decode. While armed, the counters have not yet
    // presented a pixel, so the outputs stay idle until the first pix_en.
    always_comb begin
        decode_ok     = en && !armed_reg;
        video_on_next = decode_ok && (h_state == H_ST_ACTIVE) &&
                        (v_state == V_ST_ACTIVE);
        x_next        = video_on_next ? h_cnt_reg : '0;
        y_next        = video_on_next ? v_cnt_reg : '0;
        hsync_next    = (decode_ok && (h_state == H_ST_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vsync_next    = (decode_ok && (v_state == V_ST_SYNC)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_reg         <= '0;
            armed_reg       <= 1'b1;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            pix_en_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            video_on_reg    <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
        end else begin
            div_reg         <= div_next;
            armed_reg       <= armed_next;
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            pix_en_reg      <= pix_en_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            video_on_reg    <= video_on_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
        end
    end

    assign pix_en      = pix_en_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign x           = x_reg;
    assign y           = y_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances of vga_timing_gen:
//     0: CLK_DIV=2, reduced raster 32x20 (16 active px, 12 active lines)
//     1: CLK_DIV=1, SYNC_POL=1, same reduced raster
//     2: default 640x480 parameters (one line only)
//   Expected pixels (h,v) are queued when a run is started and are popped
//   on every observed pix_en. Sync/video/coordinates are checked one
//   cycle after each pix_en.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int div; bit pol;
    } tcfg_t;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
    } pix_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] en_v;
    logic [2:0] pix_v, hs_v, vs_v, von_v, ls_v, fs_v;
    logic [9:0] x_v [3];
    logic [9:0] y_v [3];

    int   tests_run    = 0;
    int   tests_failed = 0;
    pix_t sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0)
    ) u_small (
        .clk_in(clk), .rst_n(rst_n), .en(en_v[0]), .pix_en(pix_v[0]),
        .hsync(hs_v[0]), .vsync(vs_v[0]), .video_on(von_v[0]),
        .x(x_v[0]), .y(y_v[0]), .line_start(ls_v[0]), .frame_start(fs_v[0])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b1)
    ) u_fast (
        .clk_in(clk), .rst_n(rst_n), .en(en_v[1]), .pix_en(pix_v[1]),
        .hsync(hs_v[1]), .vsync(vs_v[1]), .video_on(von_v[1]),
        .x(x_v[1]), .y(y_v[1]), .line_start(ls_v[1]), .frame_start(fs_v[1])
    );

    vga_timing_gen u_def (
        .clk_in(clk), .rst_n(rst_n), .en(en_v[2]), .pix_en(pix_v[2]),
        .hsync(hs_v[2]), .vsync(vs_v[2]), .video_on(von_v[2]),
        .x(x_v[2]), .y(y_v[2]), .line_start(ls_v[2]), .frame_start(fs_v[2])
    );

    function automatic tcfg_t cfg_of(input int sel);
        tcfg_t c;
        if (sel == 2) begin
            c = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33,
                  div:2, pol:1'b0};
        end else begin
            c = '{ha:16, hfp:4, hs:6, hbp:6, va:12, vfp:2, vs:2, vbp:4,
                  div:(sel == 1) ? 1 : 2, pol:(sel == 1)};
        end
        return c;
    endfunction

    function automatic int htot(input tcfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int vtot(input tcfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction

    // {line_start, frame_start} expected with the pix_en of pixel e
    function automatic logic [1:0] exp_pulse(input pix_t e);
        return {e.h == 10'd0, (e.h == 10'd0) && (e.v == 10'd0)};
    endfunction

    // {hsync, vsync, video_on, x, y} expected one cycle after pixel e
    function automatic logic [22:0] exp_dec(input tcfg_t c, input pix_t e);
        int   h;
        int   v;
        logic von;
        logic hs;
        logic vs;
        h   = int'(e.h);
        v   = int'(e.v);
        von = (h < c.ha) && (v < c.va);
        hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.pol : ~c.pol;
        vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.pol : ~c.pol;
        return {hs, vs, von, von ? e.h : 10'd0, von ? e.v : 10'd0};
    endfunction

    function automatic logic [22:0] idle_dec(input tcfg_t c);
        return {~c.pol, ~c.pol, 1'b0, 10'd0, 10'd0};
    endfunction

    function automatic logic [22:0] obs_dec(input int sel);
        return {hs_v[sel], vs_v[sel], von_v[sel], x_v[sel], y_v[sel]};
    endfunction

    // Queue raster positions first_p .. first_p+count-1 (pixel index order)
    task automatic push_pixels(input int sel, input int first_p, input int count);
        tcfg_t c;
        pix_t  t;
        c = cfg_of(sel);
        for (int p = first_p; p < first_p + count; p++) begin
            t.h = 10'(p % htot(c));
            t.v = 10'((p / htot(c)) % vtot(c));
            sb_q.push_back(t);
        end
    endtask

    // Drain the scoreboard against instance sel. first_lat > 0 also checks
    // the number of cycles from the call to the first pix_en.
    task automatic run_check(input int sel, input int first_lat, input int budget);
        tcfg_t c;
        pix_t  cur;
        int    cyc;
        int    last_pix;
        int    last_ls;
        int    last_fs;
        bit    pend;
        c        = cfg_of(sel);
        cyc      = 0;
        last_pix = -1;
        last_ls  = -1;
        last_fs  = -1;
        pend     = 1'b0;
        cur      = '0;
        while ((sb_q.size() > 0 || pend) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                tests_run++;
                if (obs_dec(sel) !== exp_dec(c, cur)) begin
                    tests_failed++;
                    $display("FAIL decode sel=%0d h=%0d v=%0d got=%h exp=%h",
                             sel, cur.h, cur.v, obs_dec(sel), exp_dec(c, cur));
                end
                pend = 1'b0;
            end else if (last_pix < 0) begin
                tests_run++;
                if (obs_dec(sel) !== idle_dec(c)) begin
                    tests_failed++;
                    $display("FAIL pre_start_idle sel=%0d cyc=%0d got=%h exp=%h",
                             sel, cyc, obs_dec(sel), idle_dec(c));
                end
            end
            if (sb_q.size() == 0) begin
                // Raster keeps running past the last queued pixel; ignore it.
            end else if (!pix_v[sel]) begin
                tests_run++;
                if ({ls_v[sel], fs_v[sel]} !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL stray_pulse sel=%0d cyc=%0d got=%b exp=00",
                             sel, cyc, {ls_v[sel], fs_v[sel]});
                end
            end else begin
                cur = sb_q.pop_front();
                tests_run++;
                if (last_pix < 0 && first_lat > 0 && cyc != first_lat) begin
                    tests_failed++;
                    $display("FAIL first_pix_latency sel=%0d got=%0d exp=%0d",
                             sel, cyc, first_lat);
                end else if (last_pix >= 0 && cyc - last_pix != c.div) begin
                    tests_failed++;
                    $display("FAIL pix_period sel=%0d h=%0d v=%0d got=%0d exp=%0d",
                             sel, cur.h, cur.v, cyc - last_pix, c.div);
                end
                tests_run++;
                if ({ls_v[sel], fs_v[sel]} !== exp_pulse(cur)) begin
                    tests_failed++;
                    $display("FAIL start_pulses sel=%0d h=%0d v=%0d got=%b exp=%b",
                             sel, cur.h, cur.v, {ls_v[sel], fs_v[sel]}, exp_pulse(cur));
                end
                if (ls_v[sel]) begin
                    if (last_ls >= 0) begin
                        tests_run++;
                        if (cyc - last_ls != htot(c) * c.div) begin
                            tests_failed++;
                            $display("FAIL line_period sel=%0d got=%0d exp=%0d",
                                     sel, cyc - last_ls, htot(c) * c.div);
                        end
                    end
                    last_ls = cyc;
                end
                if (fs_v[sel]) begin
                    if (last_fs >= 0) begin
                        tests_run++;
                        if (cyc - last_fs != htot(c) * vtot(c) * c.div) begin
                            tests_failed++;
                            $display("FAIL frame_period sel=%0d got=%0d exp=%0d",
                                     sel, cyc - last_fs, htot(c) * vtot(c) * c.div);
                        end
                    end
                    last_fs = cyc;
                end
                last_pix = cyc;
                pend     = 1'b1;
            end
        end
        tests_run++;
        if (sb_q.size() > 0 || pend) begin
            tests_failed++;
            $display("FAIL run_timeout sel=%0d left=%0d exp=0", sel, sb_q.size());
        end
        sb_q.delete();
    endtask

    // All outputs of instance sel at their idle values, including pix_en
    task automatic check_idle(input int sel, input string tag);
        tcfg_t c;
        c = cfg_of(sel);
        tests_run++;
        if ({pix_v[sel], ls_v[sel], fs_v[sel], obs_dec(sel)} !==
            {3'b000, idle_dec(c)}) begin
            tests_failed++;
            $display("FAIL %s sel=%0d got=%h exp=%h", tag, sel,
                     {pix_v[sel], ls_v[sel], fs_v[sel], obs_dec(sel)},
                     {3'b000, idle_dec(c)});
        end
    endtask

    task automatic go_origin();
        en_v = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_v  = 3'b111;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) check_idle(s, "reset_idle");
        en_v  = 3'b001;
        rst_n = 1'b1;
        push_pixels(0, 0, 33);
        run_check(0, 2, 200);
        go_origin();
    endtask

    task automatic test_line_default();
        @(negedge clk);
        en_v[2] = 1'b1;
        push_pixels(2, 0, 801);
        run_check(2, 2, 2000);
        go_origin();
    endtask

    task automatic test_frames();
        @(negedge clk);
        en_v[0] = 1'b1;
        push_pixels(0, 0, 2 * 32 * 20 + 1);
        run_check(0, 2, 3000);
        go_origin();
    endtask

    task automatic test_en_drop();
        @(negedge clk);
        en_v[0] = 1'b1;
        push_pixels(0, 0, 5 * 32 + 10 + 1);
        run_check(0, 2, 600);
        en_v[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle(0, "en_low_idle");
        end
        en_v[0] = 1'b1;
        push_pixels(0, 0, 33);
        run_check(0, 2, 200);
        go_origin();
    endtask

    task automatic test_params();
        @(negedge clk);
        en_v[1] = 1'b1;
        push_pixels(1, 0, 2 * 32 * 20 + 1);
        run_check(1, 1, 1500);
        go_origin();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en_v[0] = 1'b1;
        repeat (101) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle(0, "async_reset_now");
        repeat (3) begin
            @(negedge clk);
            check_idle(0, "reset_held");
        end
        rst_n = 1'b1;
        push_pixels(0, 0, 33);
        run_check(0, 2, 200);
        go_origin();
    endtask

    initial begin
        rst_n = 1'b0;
        en_v  = 3'b000;
        test_reset();
        test_line_default();
        test_frames();
        test_en_drop();
        test_params();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
